// File: rtl/fpu_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_arbiter
//   Shares one non-pipelined FPU between N_REQ requesters. A round-robin
//   arbiter picks one pending request, captures its operation and operands,
//   runs the FPU input/output handshakes and returns the result to the winner.
//   A watchdog aborts an operation that spends TIMEOUT_CYCLES in ISSUE+WAIT
//   and returns an all-ones (NaN) result flagged with rsp_err.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   req_valid/op/a/b    per-requester issue ports (packed, slice i = req i)
//   req_ack             one-cycle pulse when request i is accepted
//   rsp_valid           one-hot, result available for the granted requester
//   rsp_result/rsp_err  result data and timeout-abort flag
//   rsp_ack             requester i consumed its result
//   busy, grant_id      arbiter state != IDLE, index of current owner
//   fpu_*               handshake and data interface to the shared FPU
// -----------------------------------------------------------------------------
module fpu_arbiter #(
    parameter int N_REQ          = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int OP_WIDTH       = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*OP_WIDTH-1:0]   req_op,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]            req_ack,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_result,
    output logic                        rsp_err,
    input  logic [N_REQ-1:0]            rsp_ack,
    output logic                        busy,
    output logic [$clog2(N_REQ)-1:0]    grant_id,
    output logic [OP_WIDTH-1:0]         fpu_operation,
    output logic [DATA_WIDTH-1:0]       fpu_data_a,
    output logic [DATA_WIDTH-1:0]       fpu_data_b,
    output logic                        fpu_input_rdy,
    input  logic                        fpu_input_ack,
    input  logic                        fpu_output_rdy,
    output logic                        fpu_output_ack,
    input  logic [DATA_WIDTH-1:0]       fpu_result
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ID_W-1:0] PTR_INIT = ID_W'(N_REQ - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RESPOND = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t            state_r;
    logic [ID_W-1:0]   ptr_r;
    logic [WD_W-1:0]   wdog_r;

    logic              win_found_s;
    logic [ID_W-1:0]   win_idx_s;
    logic [OP_WIDTH-1:0]   win_op_s;
    logic [DATA_WIDTH-1:0] win_a_s;
    logic [DATA_WIDTH-1:0] win_b_s;
    logic              timeout_s;
    logic              ack_hit_s;

    function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = {N_REQ{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin search: walk from the farthest candidate down to ptr+1 so
    // the nearest requester after the pointer is the last (winning) update.
    always_comb begin
        int idx;
        idx         = 0;
        win_found_s = 1'b0;
        win_idx_s   = {ID_W{1'b0}};
        win_op_s    = {OP_WIDTH{1'b0}};
        win_a_s     = {DATA_WIDTH{1'b0}};
        win_b_s     = {DATA_WIDTH{1'b0}};
        for (int k = N_REQ; k >= 1; k--) begin
            idx         = (int'(ptr_r) + k) % N_REQ;
            win_found_s = req_valid[idx] ? 1'b1 : win_found_s;
            win_idx_s   = req_valid[idx] ? ID_W'(idx) : win_idx_s;
            win_op_s    = req_valid[idx] ? req_op[idx*OP_WIDTH +: OP_WIDTH] : win_op_s;
            win_a_s     = req_valid[idx] ? req_a[idx*DATA_WIDTH +: DATA_WIDTH] : win_a_s;
            win_b_s     = req_valid[idx] ? req_b[idx*DATA_WIDTH +: DATA_WIDTH] : win_b_s;
        end
    end

    // Watchdog expiry and owner's response acknowledge
    always_comb begin
        timeout_s = (wdog_r == WD_LAST);
        ack_hit_s = rsp_ack[grant_id];
    end

    // Arbitration, FPU handshake sequencing and response return
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            ptr_r          <= PTR_INIT;
            wdog_r         <= {WD_W{1'b0}};
            req_ack        <= {N_REQ{1'b0}};
            rsp_valid      <= {N_REQ{1'b0}};
            rsp_result     <= {DATA_WIDTH{1'b0}};
            rsp_err        <= 1'b0;
            busy           <= 1'b0;
            grant_id       <= {ID_W{1'b0}};
            fpu_operation  <= {OP_WIDTH{1'b0}};
            fpu_data_a     <= {DATA_WIDTH{1'b0}};
            fpu_data_b     <= {DATA_WIDTH{1'b0}};
            fpu_input_rdy  <= 1'b0;
            fpu_output_ack <= 1'b0;
        end else begin
            // req_ack is a single-cycle pulse; only the IDLE grant raises it
            req_ack <= {N_REQ{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (win_found_s) begin
                        grant_id      <= win_idx_s;
                        ptr_r         <= win_idx_s;
                        req_ack       <= onehot(win_idx_s);
                        fpu_operation <= win_op_s;
                        fpu_data_a    <= win_a_s;
                        fpu_data_b    <= win_b_s;
                        fpu_input_rdy <= 1'b1;
                        wdog_r        <= {WD_W{1'b0}};
                        busy          <= 1'b1;
                        state_r       <= ST_ISSUE;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    wdog_r <= wdog_r + WD_W'(1);
                    // Abort wins over a coincident input_ack so the bound is exact
                    if (timeout_s) begin
                        fpu_input_rdy <= 1'b0;
                        rsp_result    <= {DATA_WIDTH{1'b1}};
                        rsp_err       <= 1'b1;
                        rsp_valid     <= onehot(grant_id);
                        state_r       <= ST_RESPOND;
                    end else if (fpu_input_ack) begin
                        fpu_input_rdy <= 1'b0;
                        state_r       <= ST_WAIT;
                    end else begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_WAIT: begin
                    wdog_r <= wdog_r + WD_W'(1);
                    if (timeout_s) begin
                        rsp_result <= {DATA_WIDTH{1'b1}};
                        rsp_err    <= 1'b1;
                        rsp_valid  <= onehot(grant_id);
                        state_r    <= ST_RESPOND;
                    end else if (fpu_output_rdy) begin
                        rsp_result <= fpu_result;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= onehot(grant_id);
                        state_r    <= ST_RESPOND;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_RESPOND: begin
                    if (ack_hit_s) begin
                        rsp_valid      <= {N_REQ{1'b0}};
                        // After an abort the FPU may not be presenting anything
                        fpu_output_ack <= fpu_output_rdy;
                        state_r        <= ST_RELEASE;
                    end else begin
                        state_r <= ST_RESPOND;
                    end
                end
                ST_RELEASE: begin
                    // Also catches a late output_rdy from an aborted operation
                    if (fpu_output_rdy) begin
                        fpu_output_ack <= 1'b1;
                        state_r        <= ST_RELEASE;
                    end else begin
                        fpu_output_ack <= 1'b0;
                        wdog_r         <= {WD_W{1'b0}};
                        busy           <= 1'b0;
                        state_r        <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid      <= {N_REQ{1'b0}};
                    fpu_input_rdy  <= 1'b0;
                    fpu_output_ack <= 1'b0;
                    wdog_r         <= {WD_W{1'b0}};
                    busy           <= 1'b0;
                    state_r        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fpu_arbiter
//   Directed and randomized bench for fpu_arbiter. A behavioural FPU model
//   answers the handshake with programmable latency (or hangs), and a
//   round-robin reference model predicts each grant from the pending set.
// -----------------------------------------------------------------------------
module tb_fpu_arbiter;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int OW  = 4;
    localparam int TMO = 255;

    logic                clock;
    logic                reset;
    logic [N-1:0]        req_valid;
    logic [N*OW-1:0]     req_op;
    logic [N*DW-1:0]     req_a;
    logic [N*DW-1:0]     req_b;
    logic [N-1:0]        req_ack;
    logic [N-1:0]        rsp_valid;
    logic [DW-1:0]       rsp_result;
    logic                rsp_err;
    logic [N-1:0]        rsp_ack;
    logic                busy;
    logic [1:0]          grant_id;
    logic [OW-1:0]       fpu_operation;
    logic [DW-1:0]       fpu_data_a;
    logic [DW-1:0]       fpu_data_b;
    logic                fpu_input_rdy;
    logic                fpu_input_ack  = 1'b0;
    logic                fpu_output_rdy = 1'b0;
    logic                fpu_output_ack;
    logic [DW-1:0]       fpu_result     = 32'd0;

    int n_checks = 0;
    int n_errors = 0;

    // reference state
    logic [N-1:0]  pending;
    logic [OW-1:0] m_op [N];
    logic [DW-1:0] m_a  [N];
    logic [DW-1:0] m_b  [N];
    int            ptr_m;
    int            obs_grant;
    int            ack_cnt [N];
    int            snap    [N];

    // fpu model controls/state
    int            fpu_lat   = 0;
    bit            fpu_hang  = 1'b0;
    bit            fpu_flush = 1'b0;
    bit            f_busy    = 1'b0;
    bit            f_hang    = 1'b0;
    int            f_cnt     = 0;
    logic [DW-1:0] f_res     = 32'd0;

    fpu_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .OP_WIDTH(OW), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
        .rsp_err(rsp_err), .rsp_ack(rsp_ack), .busy(busy), .grant_id(grant_id),
        .fpu_operation(fpu_operation), .fpu_data_a(fpu_data_a), .fpu_data_b(fpu_data_b),
        .fpu_input_rdy(fpu_input_rdy), .fpu_input_ack(fpu_input_ack),
        .fpu_output_rdy(fpu_output_rdy), .fpu_output_ack(fpu_output_ack),
        .fpu_result(fpu_result)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "simulation time limit");
    end

    // Arithmetic stand-in for the FPU: known IEEE results for the directed
    // operands, an asymmetric mix otherwise so swapped/misrouted data shows.
    function automatic logic [DW-1:0] fpu_fn(input logic [OW-1:0] op,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        if (op == 4'b0010 && a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
        if (op == 4'b0000 && a == 32'h3F800000 && b == 32'h3C23D70A) return 32'h3F8147AE;
        return (a * 32'd3 + b) ^ ({28'd0, op} * 32'h9E3779B9);
    endfunction

    // Behavioural FPU, acting on the falling edge
    always @(negedge clock) begin
        if (!reset || fpu_flush) begin
            fpu_input_ack  = 1'b0;
            fpu_output_rdy = 1'b0;
            fpu_result     = 32'd0;
            f_busy         = 1'b0;
        end else if (f_busy) begin
            fpu_input_ack = 1'b0;
            if (fpu_output_rdy) begin
                if (fpu_output_ack) begin
                    fpu_output_rdy = 1'b0;
                    f_busy         = 1'b0;
                end
            end else if (!f_hang) begin
                if (f_cnt == 0) begin
                    fpu_output_rdy = 1'b1;
                    fpu_result     = f_res;
                end else begin
                    f_cnt--;
                end
            end
        end else if (fpu_input_rdy) begin
            fpu_input_ack = 1'b1;
            f_busy        = 1'b1;
            f_cnt         = fpu_lat;
            f_hang        = fpu_hang;
            f_res         = fpu_fn(fpu_operation, fpu_data_a, fpu_data_b);
        end else begin
            fpu_input_ack = 1'b0;
        end
    end

    // Count acceptance pulses per requester
    always @(negedge clock) begin
        for (int i = 0; i < N; i++) if (req_ack[i]) ack_cnt[i]++;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Strict round robin: first pending requester after the last winner
    function automatic int pick();
        for (int k = 1; k <= N; k++) begin
            if (pending[(ptr_m + k) % N]) return (ptr_m + k) % N;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_op[i*OW +: OW] = m_op[i];
            req_a[i*DW +: DW]  = m_a[i];
            req_b[i*DW +: DW]  = m_b[i];
        end
        req_valid = pending;
    endtask

    task automatic new_req(input int i);
        m_op[i]    = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'b0010;
        m_a[i]     = $urandom;
        m_b[i]     = $urandom;
        pending[i] = 1'b1;
        drive();
    endtask

    // One complete transaction for the predicted winner
    task automatic run_txn(input string tag, input int ack_delay, input bit tmo,
                           input logic [N-1:0] raise_mask);
        int w;
        int lat;
        bit seen;
        logic [DW-1:0] exp_res;
        w = pick();
        if (w < 0) begin
            $display("FAIL %s_bench_no_pending observed=0 expected=1", tag);
            $fatal(1, "no pending request");
        end
        exp_res = tmo ? 32'hFFFFFFFF : fpu_fn(m_op[w], m_a[w], m_b[w]);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clock);
            seen = (req_ack != '0);
        end
        check({tag, "_ack_seen"}, 128'(seen), 128'(1'b1));
        obs_grant = int'(grant_id);
        check({tag, "_req_ack"},  128'(req_ack), 128'(oh(w)));
        check({tag, "_grant_id"}, 128'(grant_id), 128'(w));
        check({tag, "_fpu_op"},   128'(fpu_operation), 128'(m_op[w]));
        check({tag, "_fpu_a"},    128'(fpu_data_a), 128'(m_a[w]));
        check({tag, "_fpu_b"},    128'(fpu_data_b), 128'(m_b[w]));
        check({tag, "_busy"},     128'(busy), 128'(1'b1));
        pending[w] = 1'b0;
        drive();
        ptr_m = w;
        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= TMO + 20 && !seen; c++) begin
            @(negedge clock);
            if (rsp_valid != '0) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        check({tag, "_rsp_seen"}, 128'(seen), 128'(1'b1));
        if (tmo) check({tag, "_timeout_cycles"}, 128'(lat), 128'(TMO));
        check({tag, "_rsp_valid"},  128'(rsp_valid), 128'(oh(w)));
        check({tag, "_rsp_result"}, 128'(rsp_result), 128'(exp_res));
        check({tag, "_rsp_err"},    128'(rsp_err), 128'(tmo));
        pending = pending | raise_mask;
        drive();
        for (int k = 0; k < ack_delay; k++) begin
            rsp_ack = (~oh(w)) & 4'($urandom);
            @(negedge clock);
            check({tag, "_hold_valid"}, 128'(rsp_valid), 128'(oh(w)));
            check({tag, "_hold_noack"}, 128'(req_ack), 128'(4'b0000));
            check({tag, "_hold_grant"}, 128'(grant_id), 128'(w));
        end
        rsp_ack = oh(w);
        @(negedge clock);
        rsp_ack = '0;
        check({tag, "_rsp_drop"},  128'(rsp_valid), 128'(4'b0000));
        check({tag, "_a_stable"},  128'(fpu_data_a), 128'(m_a[w]));
    endtask

    initial begin
        bit seen;
        reset   = 1'b0;
        pending = '0;
        rsp_ack = '0;
        ptr_m   = N - 1;
        for (int i = 0; i < N; i++) begin
            m_op[i] = '0; m_a[i] = '0; m_b[i] = '0; ack_cnt[i] = 0;
        end
        drive();
        repeat (3) @(negedge clock);
        check("reset_outputs", 128'({14'd0, req_ack, rsp_valid, rsp_result, rsp_err, busy,
              grant_id, fpu_operation, fpu_data_a, fpu_data_b, fpu_input_rdy, fpu_output_ack}),
              128'd0);
        reset = 1'b1;
        @(negedge clock);
        check("idle_busy", 128'(busy), 128'(1'b0));

        // all four requesting: grants 0,1,2,3 with one acceptance each
        fpu_lat = 2;
        for (int i = 0; i < N; i++) new_req(i);
        for (int i = 0; i < N; i++) snap[i] = ack_cnt[i];
        for (int i = 0; i < N; i++) begin
            run_txn("t2", 0, 1'b0, '0);
            check("t2_grant_seq", 128'(obs_grant), 128'(i));
        end
        for (int i = 0; i < N; i++) check("t2_one_ack", 128'(ack_cnt[i] - snap[i]), 128'(1));

        // requester 1 multiply 2.0*2.0
        fpu_lat = 0;
        m_op[1] = 4'b0010; m_a[1] = 32'h40000000; m_b[1] = 32'h40000000;
        pending = 4'b0010;
        drive();
        run_txn("t1", 0, 1'b0, '0);
        check("t1_grant", 128'(obs_grant), 128'(1));
        check("t1_result", 128'(rsp_result), 128'(32'h40800000));
        check("t1_err", 128'(rsp_err), 128'(1'b0));

        // requester 0 add, response held 10 cycles while requester 2 waits
        m_op[0] = 4'b0000; m_a[0] = 32'h3F800000; m_b[0] = 32'h3C23D70A;
        m_op[2] = 4'b0010; m_a[2] = $urandom; m_b[2] = $urandom;
        pending = 4'b0001;
        drive();
        run_txn("t3", 10, 1'b0, 4'b0100);
        check("t3_grant", 128'(obs_grant), 128'(0));
        check("t3_result", 128'(rsp_result), 128'(32'h3F8147AE));
        run_txn("t3_next", 0, 1'b0, '0);
        check("t3_next_grant", 128'(obs_grant), 128'(2));

        // hung FPU: watchdog abort
        fpu_hang = 1'b1;
        new_req(3);
        run_txn("t4", 0, 1'b1, '0);
        check("t4_result", 128'(rsp_result), 128'(32'hFFFFFFFF));
        check("t4_err", 128'(rsp_err), 128'(1'b1));
        @(negedge clock);
        check("t4_idle", 128'(busy), 128'(1'b0));
        fpu_flush = 1'b1;
        @(negedge clock);
        fpu_flush = 1'b0;
        fpu_hang  = 1'b0;

        // asynchronous reset in the middle of WAIT
        fpu_lat = 30;
        new_req(1);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clock);
            seen = (req_ack != '0);
        end
        check("t5_ack_seen", 128'(seen), 128'(1'b1));
        pending = '0;
        drive();
        repeat (5) @(negedge clock);
        check("t5_in_wait_busy", 128'(busy), 128'(1'b1));
        check("t5_in_wait_rdy", 128'(fpu_input_rdy), 128'(1'b0));
        #2 reset = 1'b0;
        #1;
        check("t5_async_reset", 128'({14'd0, req_ack, rsp_valid, rsp_result, rsp_err, busy,
              grant_id, fpu_operation, fpu_data_a, fpu_data_b, fpu_input_rdy, fpu_output_ack}),
              128'd0);
        @(negedge clock);
        @(negedge clock);
        ptr_m = N - 1;
        reset = 1'b1;
        fpu_lat = 1;
        new_req(2);
        run_txn("t5_after", 0, 1'b0, '0);
        check("t5_after_grant", 128'(obs_grant), 128'(2));

        // requester 3 must not be starved by requester 0 re-requesting
        new_req(3);
        run_txn("t6_pre", 0, 1'b0, '0);
        new_req(0);
        new_req(3);
        run_txn("t6_a", 0, 1'b0, '0);
        check("t6_first", 128'(obs_grant), 128'(0));
        new_req(0);
        run_txn("t6_b", 0, 1'b0, '0);
        check("t6_second", 128'(obs_grant), 128'(3));
        run_txn("t6_c", 0, 1'b0, '0);
        check("t6_third", 128'(obs_grant), 128'(0));

        // randomized traffic against the round-robin model
        for (int it = 0; it < 40; it++) begin
            fpu_lat = $urandom_range(0, 4);
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && $urandom_range(0, 2) != 0) new_req(i);
            end
            if (pending == '0) new_req($urandom_range(0, N - 1));
            run_txn("rand", $urandom_range(0, 3), 1'b0, '0);
        end
        for (int d = 0; d < N && pending != '0; d++) run_txn("drain", 0, 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
